smoothing_filter_ctrl: RTL and testbench

SMOOTHING_FILTER_CTRL -- requirements
Module: smoothing_filter_ctrl

---
 rtl/smoothing_filter_ctrl_pkg.sv | 6 +
 rtl/smoothing_filter_ctrl_pix_fifo2.sv | 38 +++
 rtl/smoothing_filter_ctrl.sv | 149 ++++++++++++++
 tb/tb_smoothing_filter_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/smoothing_filter_ctrl_pkg.sv
// rtl/smoothing_filter_ctrl_pkg.sv - shared FSM type and default widths for the smoothing filter controller
package smooth_pkg;
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_LAT    = 2;
endpackage

// File: rtl/smoothing_filter_ctrl_pix_fifo2.sv
// rtl/smoothing_filter_ctrl_pix_fifo2.sv - two-entry pixel FIFO between source RAM reads and filter feed
module pix_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [1:0]   count,
   output logic [W-1:0] head
);
   logic [W-1:0] mem [2];
   logic         rp;
   logic         wp;

   assign head = mem[rp];

   // The read throttle upstream guarantees push never lands on a full FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= 2'd0;
         rp     <= 1'b0;
         wp     <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp      <= ~wp;
         end
         if (pop) begin
            rp <= ~rp;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/smoothing_filter_ctrl.sv
// rtl/smoothing_filter_ctrl.sv - streams one frame from source RAM through the smoothing filter into destination RAM
// Optional cycle_count output is built when SMOOTH_CTRL_CYCLE_COUNT_EN is defined.
module smoothing_filter_ctrl
   import smooth_pkg::*;
#(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 12,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LAT    = DEF_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              filt_enb,
   output logic [DATA_W-1:0] filt_in,
   input  logic [DATA_W-1:0] filt_out,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
`ifdef SMOOTH_CTRL_CYCLE_COUNT_EN
   ,
   output logic [31:0]       cycle_count
`endif
);
   localparam int            CW       = ADDR_W + 1;
   localparam logic [CW-1:0] N_PIX    = CW'(IMG_W * IMG_H);
   localparam logic [CW-1:0] LAST_PIX = CW'(IMG_W * IMG_H - 1);
   localparam int            FW       = $clog2(LAT + 1);
   localparam logic [FW-1:0] N_FLUSH  = FW'(LAT);

   state_t            state;
   logic [CW-1:0]     rd_cnt;
   logic [CW-1:0]     pix_idx;
   logic [FW-1:0]     flush_cnt;
   logic              in_flight;
   logic [LAT-1:0]    tag_v;
   logic [ADDR_W-1:0] tag_a [LAT];
   logic [1:0]        fifo_count;
   logic [DATA_W-1:0] fifo_head;
   logic              pop;
   logic              pix_avail;
   logic              flush_avail;
   logic              tag_out;
   logic [2:0]        occupancy;

   // Reads are throttled so FIFO plus outstanding read never exceeds two entries.
   always_comb begin
      pix_avail   = (state == STREAM) && (fifo_count != 2'd0);
      flush_avail = (state == DRAIN) && (flush_cnt != N_FLUSH);
      filt_enb    = !pause && (pix_avail || flush_avail);
      pop         = !pause && pix_avail;
      filt_in     = pop ? fifo_head : '0;
      occupancy   = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
      rd_en       = (state == STREAM) && !pause && (rd_cnt != N_PIX) && (occupancy < 3'd2);
      rd_addr     = rd_en ? rd_cnt[ADDR_W-1:0] : '0;
      tag_out     = filt_enb && tag_v[LAT-1];
      wr_data     = wr_en ? filt_out : '0;
   end

   pix_fifo2 #(.W(DATA_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_flight),
      .pop   (pop),
      .din   (rd_data),
      .count (fifo_count),
      .head  (fifo_head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_cnt    <= '0;
         pix_idx   <= '0;
         flush_cnt <= '0;
         in_flight <= 1'b0;
         tag_v     <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         for (int i = 0; i < LAT; i++) tag_a[i] <= '0;
      end else begin
         in_flight <= rd_en;
         done      <= 1'b0;
         wr_en     <= tag_out;
         wr_addr   <= tag_out ? tag_a[LAT-1] : '0;
         if (rd_en) rd_cnt <= rd_cnt + CW'(1);
         // Flush samples enter the tag line as invalid, so they never produce a write.
         if (filt_enb) begin
            tag_v[0] <= pop;
            tag_a[0] <= pix_idx[ADDR_W-1:0];
            for (int i = 1; i < LAT; i++) begin
               tag_v[i] <= tag_v[i-1];
               tag_a[i] <= tag_a[i-1];
            end
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= STREAM;
                  busy      <= 1'b1;
                  rd_cnt    <= '0;
                  pix_idx   <= '0;
                  flush_cnt <= '0;
               end
            end
            STREAM: begin
               if (pop) begin
                  pix_idx <= pix_idx + CW'(1);
                  if (pix_idx == LAST_PIX) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!pause) begin
                  if (flush_avail) begin
                     flush_cnt <= flush_cnt + FW'(1);
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SMOOTH_CTRL_CYCLE_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_count <= '0;
      end else if (state == IDLE && start) begin
         cycle_count <= '0;
      end else if (busy && cycle_count != 32'hFFFF_FFFF) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_smoothing_filter_ctrl.sv
// tb/tb_smoothing_filter_ctrl.sv - directed table and sequence checks for smoothing_filter_ctrl (4x2 frame, LAT=2)
module tb_smoothing_filter_ctrl;
   logic        clk = 1'b0;
   logic        reset, start, pause;
   logic        busy, done, rd_en, filt_enb, wr_en;
   logic [11:0] rd_addr, wr_addr;
   logic [7:0]  rd_data, filt_in, filt_out, wr_data;
   logic [7:0]  p0, p1;
`ifdef SMOOTH_CTRL_CYCLE_COUNT_EN
   logic [31:0] cycle_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   smoothing_filter_ctrl #(
      .IMG_W(4), .IMG_H(2), .ADDR_W(12), .DATA_W(8), .LAT(2)
   ) u_dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause),
      .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .filt_enb(filt_enb), .filt_in(filt_in), .filt_out(filt_out),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef SMOOTH_CTRL_CYCLE_COUNT_EN
      , .cycle_count(cycle_count)
`endif
   );

   function automatic logic [7:0] src_val(input logic [11:0] a);
      logic [7:0] t;
      t = a[7:0];
      return 8'h10 + 8'd7 * t;
   endfunction

   function automatic logic [7:0] exp_wr(input logic [11:0] a);
      return src_val(a) ^ 8'h5A;
   endfunction

   // Source RAM with one-cycle read latency, and a LAT=2 filter that emits sample k xor 5A.
   always @(posedge clk) begin
      if (rd_en) rd_data <= src_val(rd_addr);
      if (filt_enb) begin
         p0       <= filt_in;
         p1       <= p0;
         filt_out <= p1 ^ 8'h5A;
      end
   end

   typedef struct packed {
      logic        rd_en;
      logic [11:0] rd_addr;
      logic        filt_enb;
      logic [7:0]  filt_in;
      logic        wr_en;
      logic [11:0] wr_addr;
      logic [7:0]  wr_data;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t tbl [16];

   function automatic vec_t row(input int re, ra, fe, fi, we, wa, wd, b, d);
      vec_t v;
      v.rd_en = re[0]; v.rd_addr = ra[11:0]; v.filt_enb = fe[0]; v.filt_in = fi[7:0];
      v.wr_en = we[0]; v.wr_addr = wa[11:0]; v.wr_data = wd[7:0]; v.busy = b[0]; v.done = d[0];
      return v;
   endfunction

   function automatic vec_t outs();
      return '{rd_en, rd_addr, filt_enb, filt_in, wr_en, wr_addr, wr_data, busy, done};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; pause = 1'b0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   int wr_cnt, done_cnt, done_cyc, first_wr_cyc, last_wr_cyc;
   int pause_viol, zero_viol, order_bad, data_bad, busy_at_done;
   int rd_after_cyc;
   logic [11:0] rd_after_addr;
   logic [1:0]  fifo_log [32];

   task automatic run(input int ncyc, input logic [31:0] smask, pmask, rmask, zmask);
      wr_cnt = 0; done_cnt = 0; done_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
      pause_viol = 0; zero_viol = 0; order_bad = 0; data_bad = 0; busy_at_done = 0;
      rd_after_cyc = -1; rd_after_addr = '1;
      for (int c = 0; c < ncyc; c++) begin
         start = smask[c]; pause = pmask[c]; reset = rmask[c];
         @(negedge clk);
         if (pmask[c] && (rd_en || filt_enb)) pause_viol++;
         if (zmask[c] && (outs() != '0)) zero_viol++;
         fifo_log[c] = u_dut.u_fifo.count;
         if (wr_en) begin
            if (int'(wr_addr) != wr_cnt) order_bad++;
            if (wr_data != exp_wr(wr_addr)) data_bad++;
            wr_cnt++;
            if (first_wr_cyc < 0) first_wr_cyc = c;
            last_wr_cyc = c;
         end
         if (rd_en && rd_after_cyc < 0 && rmask != 0 && c > 7) begin
            rd_after_cyc  = c;
            rd_after_addr = rd_addr;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
            if (busy) busy_at_done++;
         end
         next_cycle();
      end
      start = 1'b0; pause = 1'b0; reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; pause = 1'b0;
      next_cycle(); next_cycle(); next_cycle();
      @(negedge clk);
      check("reset_outputs", outs(), '0);
`ifdef SMOOTH_CTRL_CYCLE_COUNT_EN
      check("reset_cycle_count", cycle_count, 0);
`endif
      next_cycle();
      reset = 1'b0;
      next_cycle();

      //            rd  addr fe  fin   we  wa  wd     busy done
      tbl[0]  = row(0, 0,  0, 'h00, 0, 0, 'h00, 0, 0);
      tbl[1]  = row(1, 0,  0, 'h00, 0, 0, 'h00, 1, 0);
      tbl[2]  = row(1, 1,  0, 'h00, 0, 0, 'h00, 1, 0);
      tbl[3]  = row(1, 2,  1, 'h10, 0, 0, 'h00, 1, 0);
      tbl[4]  = row(1, 3,  1, 'h17, 0, 0, 'h00, 1, 0);
      tbl[5]  = row(1, 4,  1, 'h1E, 0, 0, 'h00, 1, 0);
      tbl[6]  = row(1, 5,  1, 'h25, 1, 0, 'h4A, 1, 0);
      tbl[7]  = row(1, 6,  1, 'h2C, 1, 1, 'h4D, 1, 0);
      tbl[8]  = row(1, 7,  1, 'h33, 1, 2, 'h44, 1, 0);
      tbl[9]  = row(0, 0,  1, 'h3A, 1, 3, 'h7F, 1, 0);
      tbl[10] = row(0, 0,  1, 'h41, 1, 4, 'h76, 1, 0);
      tbl[11] = row(0, 0,  1, 'h00, 1, 5, 'h69, 1, 0);
      tbl[12] = row(0, 0,  1, 'h00, 1, 6, 'h60, 1, 0);
      tbl[13] = row(0, 0,  0, 'h00, 1, 7, 'h1B, 1, 0);
      tbl[14] = row(0, 0,  0, 'h00, 0, 0, 'h00, 0, 1);
      tbl[15] = row(0, 0,  0, 'h00, 0, 0, 'h00, 0, 0);

      for (int c = 0; c < 16; c++) begin
         start = (c == 0);
         @(negedge clk);
         check($sformatf("nominal_cycle_%0d", c), outs(), tbl[c]);
         next_cycle();
      end
      start = 1'b0;
`ifdef SMOOTH_CTRL_CYCLE_COUNT_EN
      check("nominal_cycle_count", cycle_count, 13);
`endif

      // Pause during STREAM at cycles 4..6
      do_reset();
      run(20, 32'h1, 32'h70, 32'h0, 32'h0);
      check("pause_no_issue", pause_viol, 0);
      check("pause_fifo_full_c5", fifo_log[5], 2);
      check("pause_fifo_full_c6", fifo_log[6], 2);
      check("pause_write_count", wr_cnt, 8);
      check("pause_write_order", order_bad, 0);
      check("pause_write_data", data_bad, 0);
      check("pause_done_cycle", done_cyc, 17);
`ifdef SMOOTH_CTRL_CYCLE_COUNT_EN
      check("pause_cycle_count_hold", cycle_count, 16);
`endif

      // Pause during DRAIN at cycles 11..12
      do_reset();
      run(20, 32'h1, 32'h1800, 32'h0, 32'h0);
      check("drain_pause_no_flush", pause_viol, 0);
      check("drain_pause_last_write", last_wr_cyc, 15);
      check("drain_pause_write_count", wr_cnt, 8);
      check("drain_pause_write_data", data_bad, 0);
      check("drain_pause_done_cycle", done_cyc, 16);

      // Reset mid-frame at cycle 5, restart at cycle 8
      do_reset();
      run(26, 32'h101, 32'h0, 32'h20, 32'hC0);
      check("midreset_outputs_zero", zero_viol, 0);
      check("midreset_restart_rd_cycle", rd_after_cyc, 9);
      check("midreset_restart_rd_addr", rd_after_addr, 0);
      check("midreset_first_write", first_wr_cyc, 14);
      check("midreset_write_count", wr_cnt, 8);
      check("midreset_write_order", order_bad, 0);
      check("midreset_done_cycle", done_cyc, 22);

      // start while busy (cycle 3) and in the DONE cycle (cycle 14) are ignored
      do_reset();
      run(30, 32'h4009, 32'h0, 32'h0, 32'h0);
      check("ignored_start_write_count", wr_cnt, 8);
      check("ignored_start_done_count", done_cnt, 1);
      check("ignored_start_done_cycle", done_cyc, 14);
      check("ignored_start_busy_at_done", busy_at_done, 0);
      check("ignored_start_write_data", data_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
